// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop synchronizer feeding a four-state stability FSM.
// A new level is accepted only after it has been seen for STABLE_CYCLES+1 consecutive samples.
module sw_debounce #(
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned CNT_W         = 20
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       SW,
   output logic       oSW,
   output logic       oRISE,
   output logic       oFALL,
   output logic       oTOGGLE,
   output logic [7:0] oPRESS,
   output logic [1:0] oState
);

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_WAIT_H = 2'd1,
      S_HIGH   = 2'd2,
      S_WAIT_L = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic             s1;
   logic             s2;
   logic             swS;
   logic             riseNext;
   logic             fallNext;

   assign swS    = s2;
   assign oState = state;

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      riseNext  = 1'b0;
      fallNext  = 1'b0;
      case (state)
         S_LOW: begin
            if (swS) begin
               stateNext = S_WAIT_H;
               cntNext   = '0;
            end
         end
         S_WAIT_H: begin
            // A single low sample throws the whole window away.
            if (!swS) begin
               stateNext = S_LOW;
               cntNext   = '0;
            end else if (cnt == CNT_LAST) begin
               stateNext = S_HIGH;
               cntNext   = '0;
               riseNext  = 1'b1;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (!swS) begin
               stateNext = S_WAIT_L;
               cntNext   = '0;
            end
         end
         S_WAIT_L: begin
            if (swS) begin
               stateNext = S_HIGH;
               cntNext   = '0;
            end else if (cnt == CNT_LAST) begin
               stateNext = S_LOW;
               cntNext   = '0;
               fallNext  = 1'b1;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         default: begin
            stateNext = S_LOW;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         state   <= S_LOW;
         cnt     <= '0;
         oSW     <= 1'b0;
         oRISE   <= 1'b0;
         oFALL   <= 1'b0;
         oTOGGLE <= 1'b0;
         oPRESS  <= 8'd0;
      end else begin
         s1    <= SW;
         s2    <= s1;
         state <= stateNext;
         cnt   <= cntNext;
         oRISE <= riseNext;
         oFALL <= fallNext;
         if (riseNext) begin
            oSW     <= 1'b1;
            oTOGGLE <= ~oTOGGLE;
            oPRESS  <= oPRESS + 8'd1;
         end
         if (fallNext) begin
            oSW <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random switch activity, all checked
// cycle by cycle against a sample-history model of the debouncing rule.
module tb_sw_debounce;

   localparam int STABLE = 4;

   logic       iCLK = 1'b0;
   logic       iRST = 1'b1;
   logic       SW   = 1'b0;
   logic       oSW;
   logic       oRISE;
   logic       oFALL;
   logic       oTOGGLE;
   logic [7:0] oPRESS;
   logic [1:0] oState;

   sw_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .SW     (SW),
      .oSW    (oSW),
      .oRISE  (oRISE),
      .oFALL  (oFALL),
      .oTOGGLE(oTOGGLE),
      .oPRESS (oPRESS),
      .oState (oState)
   );

   // clock / reset
   always #10 iCLK = ~iCLK;

   int nChecks = 0;
   int nFail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nChecks++;
      if (obs !== expv) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0t", tag, obs, expv, $time);
      end
   endtask

   // reference model: the accepted level flips once the synchronized input has
   // disagreed with it for STABLE+1 samples in a row; sync delay is two samples
   logic       p1 = 1'b0;
   logic       p2 = 1'b0;
   logic       hist[$];
   logic       mSw = 1'b0;
   logic       mRise = 1'b0;
   logic       mFall = 1'b0;
   logic       mTog = 1'b0;
   logic [7:0] mPress = 8'd0;

   // scoreboard: expected oPRESS value for each accepted rise
   logic [7:0] exp_q[$];

   int cyc         = 0;
   int lastRiseCyc = -1;
   int riseSeen    = 0;
   int fallSeen    = 0;

   task automatic modelEdge(input logic rstIn, input logic swIn);
      logic d;
      logic allDiffer;
      mRise = 1'b0;
      mFall = 1'b0;
      if (rstIn) begin
         p1 = 1'b0;
         p2 = 1'b0;
         hist.delete();
         mSw    = 1'b0;
         mTog   = 1'b0;
         mPress = 8'd0;
      end else begin
         d  = p2;
         p2 = p1;
         p1 = swIn;
         hist.push_back(d);
         while (hist.size() > STABLE + 1) void'(hist.pop_front());
         allDiffer = (hist.size() == STABLE + 1);
         foreach (hist[i]) if (hist[i] == mSw) allDiffer = 1'b0;
         if (allDiffer) begin
            mSw = ~mSw;
            hist.delete();
            if (mSw) begin
               mRise  = 1'b1;
               mTog   = ~mTog;
               mPress = mPress + 8'd1;
               exp_q.push_back(mPress);
            end else begin
               mFall = 1'b1;
            end
         end
      end
   endtask

   // one clock: model the edge, then compare away from it
   task automatic step();
      logic [7:0] e;
      @(posedge iCLK);
      modelEdge(iRST, SW);
      #1;
      cyc++;
      check("oSW", oSW, mSw);
      check("oRISE", oRISE, mRise);
      check("oFALL", oFALL, mFall);
      check("oTOGGLE", oTOGGLE, mTog);
      check("oPRESS", oPRESS, mPress);
      check("rise_fall_excl", oRISE & oFALL, 0);
      if (oRISE) begin
         riseSeen++;
         lastRiseCyc = cyc;
         if (exp_q.size() == 0) check("rise_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("press_on_rise", oPRESS, e);
         end
      end
      if (oFALL) fallSeen++;
      if (iRST) exp_q.delete();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic setSw(input logic v, input int n);
      SW = v;
      run(n);
   endtask

   int t0;
   int r0;
   int f0;
   int len;

   initial begin
      // reset
      iRST = 1'b1;
      SW   = 1'b0;
      run(3);
      check("rst_oSW", oSW, 0);
      check("rst_oRISE", oRISE, 0);
      check("rst_oFALL", oFALL, 0);
      check("rst_oTOGGLE", oTOGGLE, 0);
      check("rst_oPRESS", oPRESS, 0);
      check("rst_state", oState, 0);
      iRST = 1'b0;
      run(5);

      // clean press
      t0 = cyc; r0 = riseSeen; lastRiseCyc = -1;
      setSw(1'b1, 20);
      check("press_latency", lastRiseCyc - t0, 7);
      check("press_count", riseSeen - r0, 1);
      check("press_oSW", oSW, 1);
      check("press_oPRESS", oPRESS, 1);
      check("press_oTOGGLE", oTOGGLE, 1);

      // release
      t0 = cyc; f0 = fallSeen;
      SW = 1'b0;
      step();
      begin : rel_wait
         for (int i = 0; i < 20; i++) begin
            if (oFALL) disable rel_wait;
            step();
         end
      end
      check("release_latency", cyc - t0, 7);
      run(10);
      check("release_count", fallSeen - f0, 1);
      check("release_oPRESS", oPRESS, 1);
      check("release_oTOGGLE", oTOGGLE, 1);

      // bounce then hold high
      r0 = riseSeen; f0 = fallSeen;
      setSw(1'b1, 2); setSw(1'b0, 2); setSw(1'b1, 2); setSw(1'b0, 2);
      t0 = cyc; lastRiseCyc = -1;
      setSw(1'b1, 20);
      check("bounce_rises", riseSeen - r0, 1);
      check("bounce_falls", fallSeen - f0, 0);
      check("bounce_latency", lastRiseCyc - t0, 7);
      setSw(1'b0, 20);

      // short glitch
      r0 = riseSeen; f0 = fallSeen;
      setSw(1'b1, 1);
      setSw(1'b0, 20);
      check("glitch_rises", riseSeen - r0, 0);
      check("glitch_oSW", oSW, 0);

      // reset mid-count, switch held high through release
      SW = 1'b1;
      run(4);
      r0 = riseSeen;
      iRST = 1'b1;
      step();
      check("midrst_oSW", oSW, 0);
      check("midrst_oPRESS", oPRESS, 0);
      check("midrst_oTOGGLE", oTOGGLE, 0);
      iRST = 1'b0;
      t0 = cyc; lastRiseCyc = -1;
      run(20);
      check("midrst_rises", riseSeen - r0, 1);
      check("midrst_latency", lastRiseCyc - t0, 7);
      setSw(1'b0, 20);

      // wrap: start from reset, 256 accepted presses
      iRST = 1'b1;
      run(2);
      iRST = 1'b0;
      for (int k = 0; k < 256; k++) begin
         setSw(1'b1, 10);
         if (k == 254) check("wrap_255", oPRESS, 255);
         setSw(1'b0, 10);
      end
      check("wrap_oPRESS", oPRESS, 0);
      check("wrap_oTOGGLE", oTOGGLE, 0);

      // random activity with occasional resets
      for (int k = 0; k < 600; k++) begin
         SW   = 1'($urandom_range(0, 1));
         len  = $urandom_range(1, 9);
         iRST = ($urandom_range(0, 99) == 0);
         step();
         iRST = 1'b0;
         run(len - 1);
      end
      SW = 1'b0;
      run(20);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
